// File: rtl/spi_mem_arbiter.sv
// SPI-command front end sharing one synchronous RAM port with a local host.
// Round-robin between a one-entry SPI pending buffer and the host requester.
module spi_mem_arbiter #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [9:0]        rx_data,
  input  logic              rx_valid,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_rvalid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              ovr_err
);

  typedef enum logic [1:0] {IDLE, ACCESS, RD_WAIT} state_t;

  localparam logic [1:0] OP_WADDR = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_RADDR = 2'b10;
  localparam logic [1:0] OP_READ  = 2'b11;
  localparam logic       OWN_SPI  = 1'b0;
  localparam logic       OWN_HOST = 1'b1;

  state_t              state_q;
  logic [ADDR_W-1:0]   wr_addr_q, rd_addr_q;
  logic                last_grant_q;
  logic                spi_pend_q, pend_we_q;
  logic [ADDR_W-1:0]   pend_addr_q;
  logic [DATA_W-1:0]   pend_wdata_q;
  logic                mem_en_q, mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic [7:0]          tx_data_q;
  logic                tx_valid_q;
  logic                host_gnt_q, host_rvalid_q;
  logic [DATA_W-1:0]   host_rdata_q;
  logic                ovr_err_q;

  logic [1:0]          rx_op;
  logic [7:0]          rx_pay;
  logic                spi_win_c, host_win_c;

  assign rx_op  = rx_data[9:8];
  assign rx_pay = rx_data[7:0];

  // Round-robin: on contention the requester that did not win last time goes.
  always_comb begin
    spi_win_c  = 1'b0;
    host_win_c = 1'b0;
    if (state_q == IDLE) begin
      spi_win_c  = spi_pend_q && (!host_req || (last_grant_q == OWN_HOST));
      host_win_c = host_req && !spi_win_c;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      wr_addr_q     <= '0;
      rd_addr_q     <= '0;
      last_grant_q  <= OWN_HOST;
      spi_pend_q    <= 1'b0;
      pend_we_q     <= 1'b0;
      pend_addr_q   <= '0;
      pend_wdata_q  <= '0;
      mem_en_q      <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      tx_data_q     <= '0;
      tx_valid_q    <= 1'b0;
      host_gnt_q    <= 1'b0;
      host_rvalid_q <= 1'b0;
      host_rdata_q  <= '0;
      ovr_err_q     <= 1'b0;
    end else begin
      host_gnt_q    <= 1'b0;
      host_rvalid_q <= 1'b0;

      if (rx_valid) begin
        tx_valid_q <= 1'b0;
        unique case (rx_op)
          OP_WADDR: wr_addr_q <= ADDR_W'(rx_pay);
          OP_RADDR: rd_addr_q <= ADDR_W'(rx_pay);
          OP_WRITE, OP_READ: begin
            // A full buffer (including one being granted this cycle) drops the op.
            if (spi_pend_q) begin
              ovr_err_q <= 1'b1;
            end else begin
              spi_pend_q   <= 1'b1;
              pend_we_q    <= (rx_op == OP_WRITE);
              pend_addr_q  <= (rx_op == OP_WRITE) ? wr_addr_q : rd_addr_q;
              pend_wdata_q <= DATA_W'(rx_pay);
            end
          end
        endcase
      end

      unique case (state_q)
        IDLE: begin
          if (spi_win_c) begin
            mem_en_q     <= 1'b1;
            mem_we_q     <= pend_we_q;
            mem_addr_q   <= pend_addr_q;
            mem_wdata_q  <= pend_wdata_q;
            last_grant_q <= OWN_SPI;
            spi_pend_q   <= 1'b0;
            state_q      <= ACCESS;
          end else if (host_win_c) begin
            mem_en_q     <= 1'b1;
            mem_we_q     <= host_we;
            mem_addr_q   <= host_addr;
            mem_wdata_q  <= host_wdata;
            last_grant_q <= OWN_HOST;
            host_gnt_q   <= 1'b1;
            state_q      <= ACCESS;
          end
        end
        ACCESS: begin
          mem_en_q <= 1'b0;
          mem_we_q <= 1'b0;
          state_q  <= mem_we_q ? IDLE : RD_WAIT;
        end
        RD_WAIT: begin
          if (last_grant_q == OWN_SPI) begin
            tx_data_q  <= 8'(mem_rdata);
            tx_valid_q <= 1'b1;
          end else begin
            host_rdata_q  <= mem_rdata;
            host_rvalid_q <= 1'b1;
          end
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx_data     = tx_data_q;
  assign tx_valid    = tx_valid_q;
  assign host_gnt    = host_gnt_q;
  assign host_rdata  = host_rdata_q;
  assign host_rvalid = host_rvalid_q;
  assign mem_en      = mem_en_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign ovr_err     = ovr_err_q;

endmodule

// File: doc/spi_mem_arbiter.md
Name: spi_mem_arbiter

Overview:
Controller between the SPI slave's parallel side and a single-port synchronous RAM. It decodes 10-bit SPI command words (2-bit opcode, 8-bit payload) into address-latch, write and read operations. It shares the one RAM port with a local host requester using round-robin arbitration. Read data is returned to the SPI slave as tx_data/tx_valid.

Parameters:
ADDR_W, 8, RAM address width; must be <= 8 (SPI payload width).
DATA_W, 8, RAM data width; fixed at 8 for the SPI path.

Ports:
clk  in  1  clock
rst_n  in  1  reset
rx_data  in  10  SPI command word: [9:8] opcode, [7:0] payload
rx_valid  in  1  one-cycle strobe; rx_data is valid
tx_data  out  8  read data to SPI slave
tx_valid  out  1  level; tx_data is valid for shifting out
host_req  in  1  host memory request; held until host_gnt
host_we  in  1  1 = write, 0 = read
host_addr  in  ADDR_W  host address
host_wdata  in  DATA_W  host write data
host_gnt  out  1  one-cycle pulse; host request accepted
host_rdata  out  DATA_W  host read data
host_rvalid  out  1  one-cycle pulse; host_rdata is valid
mem_en  out  1  RAM enable
mem_we  out  1  RAM write enable
mem_addr  out  ADDR_W  RAM address
mem_wdata  out  DATA_W  RAM write data
mem_rdata  in  DATA_W  RAM read data; valid the cycle after mem_en=1, mem_we=0
ovr_err  out  1  sticky SPI overrun flag

Behaviour:
- Reset is asynchronous, active-low (rst_n); clock is clk. On reset, all outputs are 0; wr_addr, rd_addr and last_grant (=HOST) are reset; the pending SPI op is discarded. This also applies when reset is asserted mid-access.
- Opcode decode on rx_valid:
  - 00: wr_addr <= payload[ADDR_W-1:0]. Takes effect in the next cycle; no RAM access.
  - 01: queue write {wr_addr, payload}.
  - 10: rd_addr <= payload. Takes effect in the next cycle; no RAM access.
  - 11: queue read {rd_addr}; payload is ignored.
- Any accepted rx_valid clears tx_valid in the next cycle.
- SPI pending buffer:
  - One entry; captures we/addr/wdata at rx_valid.
  - The address is captured at acceptance, so a later 00/10 does not alter a queued op.
  - If an op-01/11 arrives while the buffer is full, or in the same cycle it is consumed by a grant: the new op is dropped and ovr_err is set. ovr_err clears only on reset.
- FSM states: IDLE, ACCESS, RD_WAIT.
- IDLE:
  - If spi_pend and host_req are both set, grant the requester that is not last_grant. Otherwise grant whichever requester is set.
  - On a grant: register mem_addr, mem_we and mem_wdata from the winner; update last_grant; clear spi_pend (SPI winner) or pulse host_gnt in the next cycle (host winner); go to ACCESS.
- ACCESS: mem_en=1 for exactly this cycle. A write returns to IDLE; a read goes to RD_WAIT.
- RD_WAIT:
  - Sample mem_rdata.
  - SPI owner: next cycle, tx_data <= mem_rdata and tx_valid <= 1 (held high until the next rx_valid).
  - Host owner: next cycle, host_rdata <= mem_rdata and host_rvalid pulses.
  - Return to IDLE.
- mem_en is 0 in IDLE and RD_WAIT. At most one access is in flight.
- Latency:
  - SPI read: rx_valid at cycle 0, pend at 1, grant in IDLE at 1, mem_en at 2, tx_valid at 4.
  - SPI write: mem_en at cycle 2.
  - Host (req seen in IDLE at cycle t): host_gnt and mem_en at t+1; host_rvalid at t+3.
- Simultaneous events:
  - rx_valid with op-00/10 during any state updates the address register immediately. This does not disturb an in-flight access.
  - host_req deasserted before grant is ignored. The host must not drop it.
- Widths: the payload is truncated to ADDR_W for addresses. No wrap logic is needed beyond the natural register width.

Test Plan:
- Reset, then SPI 0x005 (waddr=5) and 0x1A5 (write A5) -> mem_en=1, mem_we=1, mem_addr=5, mem_wdata=A5 at cycle 2 after the second rx_valid.
- SPI 0x205 then 0x300, with RAM[5]=A5 -> tx_data=A5, tx_valid=1 four cycles after the 0x300 strobe, held until the next rx_valid, then 0.
- host_req read addr 0x10 and SPI write queued in the same cycle after reset -> SPI granted first (last_grant=HOST); host_gnt pulse 2 cycles later; host_rvalid with RAM[0x10].
- Back-to-back contention over 4 requests each -> grants alternate SPI/HOST, with no starvation.
- Two op-01 strobes 1 cycle apart while the host holds the port -> first queued, second dropped, ovr_err=1 and sticky.
- rst_n asserted during ACCESS of a read -> all outputs 0 immediately; no tx_valid after release; pending cleared.
